// File: rtl/fft_sample_loader_pkg.sv
// Shared constants, FSM encoding and complex-word helpers for the FFT sample loader.
package fft_sample_loader_pkg;

  localparam int FLT_BIAS = 127;
  localparam int FLT_MW   = 23;
  localparam int FLT_EW   = 8;
  localparam int CW_HALF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_KICK,
    ST_WAIT
  } state_e;

  function automatic logic [2*CW_HALF-1:0] cw_pack(input logic [CW_HALF-1:0] re,
                                                   input logic [CW_HALF-1:0] im);
    return {re, im};
  endfunction

  function automatic logic [CW_HALF-1:0] cw_re(input logic [2*CW_HALF-1:0] w);
    return w[2*CW_HALF-1:CW_HALF];
  endfunction

  function automatic logic [CW_HALF-1:0] cw_im(input logic [2*CW_HALF-1:0] w);
    return w[CW_HALF-1:0];
  endfunction

endpackage

// File: rtl/fft_sample_loader_int_to_float.sv
// Exact signed-integer to IEEE-754 single converter; 2 registered stages
// (abs + leading-one, then normalize + pack), valid tag travels alongside.
module int_to_float
  import fft_sample_loader_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld_i,
  input  logic [SW-1:0] in_dat_i,
  output logic          out_vld_o,
  output logic [31:0]   out_dat_o
);

  localparam int MW = SW + 1;
  localparam int PW = $clog2(SW + 1);

  logic [MW-1:0] ext;
  logic [MW-1:0] mag;
  logic [PW-1:0] lead;

  logic          s1_vld_q;
  logic          s1_sign_q;
  logic [MW-1:0] s1_mag_q;
  logic [PW-1:0] s1_lead_q;

  logic [FLT_EW-1:0] exp_w;
  logic [31:0]       shifted;
  logic [31:0]       packed_w;

  logic        out_vld_q;
  logic [31:0] out_dat_q;

  // One extra magnitude bit so that the most negative sample still fits.
  always_comb begin
    ext  = {in_dat_i[SW-1], in_dat_i};
    mag  = in_dat_i[SW-1] ? (~ext + MW'(1)) : ext;
    lead = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lead = PW'(i);
    end
  end

  always_comb begin
    exp_w    = FLT_EW'(FLT_BIAS) + FLT_EW'(s1_lead_q);
    shifted  = 32'(s1_mag_q) << (FLT_MW - int'(s1_lead_q));
    packed_w = {s1_sign_q, exp_w, shifted[FLT_MW-1:0]};
    if (s1_mag_q == '0) packed_w = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_lead_q <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      s1_vld_q  <= in_vld_i;
      s1_sign_q <= in_dat_i[SW-1];
      s1_mag_q  <= mag;
      s1_lead_q <= lead;
      out_vld_q <= s1_vld_q;
      out_dat_q <= packed_w;
    end
  end

  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Streams N signed samples per frame into the FFT memory as float reals, kicks the
// FFT, then holds off new samples until fft_done; writes land 2 cycles after acceptance.
module fft_sample_loader
  import fft_sample_loader_pkg::*;
#(
  parameter int LOGN = 12,
  parameter int SW   = 16,
  parameter int CW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [SW-1:0]   s_data,
  output logic            fft_we,
  output logic            fft_rev,
  output logic [LOGN-1:0] fft_addr,
  output logic [CW-1:0]   fft_din,
  output logic            fft_sig,
  input  logic            fft_done,
  output logic            busy,
  output logic [15:0]     frame_cnt
);

  localparam logic [LOGN:0] N_CNT = {1'b1, {LOGN{1'b0}}};

  state_e        state_q, state_d;
  logic [LOGN:0] acc_cnt_q, acc_cnt_d;
  logic [LOGN:0] wr_cnt_q, wr_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic            fft_we_q;
  logic [LOGN-1:0] fft_addr_q;
  logic [CW-1:0]   fft_din_q;
  logic            fft_sig_q;

  logic        hs;
  logic        cv_vld;
  logic [31:0] cv_dat;

  assign s_ready = (state_q == ST_FILL) && (acc_cnt_q < N_CNT);
  assign hs      = s_valid && s_ready;

  int_to_float #(.SW(SW)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (hs),
    .in_dat_i  (s_data),
    .out_vld_o (cv_vld),
    .out_dat_o (cv_dat)
  );

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (cv_vld) wr_cnt_d = wr_cnt_q + (LOGN+1)'(1);
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_FILL;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      ST_FILL: begin
        if (hs) acc_cnt_d = acc_cnt_q + (LOGN+1)'(1);
        if (acc_cnt_d == N_CNT) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_cnt_q == N_CNT) state_d = ST_KICK;
      end
      ST_KICK: state_d = ST_WAIT;
      ST_WAIT: begin
        // enable is only sampled here, so dropping it mid-frame lets the frame finish.
        if (fft_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = enable ? ST_FILL : ST_IDLE;
          acc_cnt_d   = '0;
          wr_cnt_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      frame_cnt_q <= '0;
      fft_we_q    <= 1'b0;
      fft_addr_q  <= '0;
      fft_din_q   <= '0;
      fft_sig_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      fft_we_q    <= cv_vld;
      // Registered from KICK so one idle cycle separates the last write from the start pulse.
      fft_sig_q   <= (state_q == ST_KICK);
      if (cv_vld) begin
        fft_addr_q <= wr_cnt_q[LOGN-1:0];
        fft_din_q  <= CW'(cw_pack(cv_dat, '0));
      end
    end
  end

  assign fft_we    = fft_we_q;
  assign fft_rev   = fft_we_q;
  assign fft_addr  = fft_addr_q;
  assign fft_din   = fft_din_q;
  assign fft_sig   = fft_sig_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader with LOGN=3: conversion values, write timing,
// fft_done filtering, enable drop and mid-frame reset.
module tb_fft_sample_loader;

  localparam int LOGN = 3;
  localparam int SW   = 16;
  localparam int CW   = 64;
  localparam int N    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            s_valid;
  logic            s_ready;
  logic [SW-1:0]   s_data;
  logic            fft_we;
  logic            fft_rev;
  logic [LOGN-1:0] fft_addr;
  logic [CW-1:0]   fft_din;
  logic            fft_sig;
  logic            fft_done;
  logic            busy;
  logic [15:0]     frame_cnt;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;

  int          wa[$];
  logic [63:0] wd[$];
  logic        wr[$];
  int          wc[$];
  int          sc[$];
  int          hsc[N];

  logic [15:0] v1[N] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0002,
                         16'h8000, 16'h7FFF, 16'h0064, 16'hFF9C};
  logic [31:0] e1[N] = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
                         32'hC700_0000, 32'h46FF_FE00, 32'h42C8_0000, 32'hC2C8_0000};
  logic [15:0] v2[N] = '{16'd3, 16'hFFFE, 16'd16, 16'd255,
                         16'd1024, 16'hFFFD, 16'd7, 16'hC000};
  logic [31:0] e2[N] = '{32'h4040_0000, 32'hC000_0000, 32'h4180_0000, 32'h437F_0000,
                         32'h4480_0000, 32'hC040_0000, 32'h40E0_0000, 32'hC680_0000};

  fft_sample_loader #(.LOGN(LOGN), .SW(SW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .fft_we    (fft_we),
    .fft_rev   (fft_rev),
    .fft_addr  (fft_addr),
    .fft_din   (fft_din),
    .fft_sig   (fft_sig),
    .fft_done  (fft_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fft_we) begin
      wa.push_back(int'(fft_addr));
      wd.push_back(fft_din);
      wr.push_back(fft_rev);
      wc.push_back(cyc);
    end
    if (fft_sig) sc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wr.delete(); wc.delete(); sc.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; fft_done = 1'b0;
    tick(); tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fft_we", fft_we, 0);
    chk("rst_fft_rev", fft_rev, 0);
    chk("rst_fft_addr", fft_addr, 0);
    chk("rst_fft_din", fft_din, 0);
    chk("rst_fft_sig", fft_sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    tick();
    chk("fill_busy", busy, 1);

    // Frame 1: back-to-back samples, reference conversion vectors.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = v1[i];
      chk($sformatf("f1_rdy%0d", i), s_ready, 1);
      tick();
      hsc[i] = cyc;
    end
    s_valid = 1'b0;
    chk("f1_rdy_low", s_ready, 0);
    for (int k = 0; k < 20 && sc.size() == 0; k++) tick();
    tick();
    chk("f1_nwrites", wa.size(), N);
    for (int i = 0; i < wa.size() && i < N; i++) begin
      chk($sformatf("f1_addr%0d", i), wa[i], i);
      chk($sformatf("f1_din%0d", i), wd[i], {e1[i], 32'h0});
      chk($sformatf("f1_rev%0d", i), wr[i], 1);
      chk($sformatf("f1_lat%0d", i), wc[i], hsc[i] + 2);
    end
    chk("f1_nsig", sc.size(), 1);
    if (sc.size() > 0 && wc.size() > 0) chk("f1_sig_gap", sc[0] - wc[wc.size()-1], 2);
    tick(); tick();
    chk("wait_s_ready", s_ready, 0);
    chk("wait_busy", busy, 1);
    chk("wait_frame_cnt", frame_cnt, 0);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("done_frame_cnt", frame_cnt, 1);
    chk("turnaround_s_ready", s_ready, 1);

    // fft_done in FILL must be ignored.
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("done_in_fill", frame_cnt, 1);

    // Frame 2: s_valid every other cycle, enable dropped after the first sample.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = v2[i];
      tick();
      s_valid = 1'b0;
      if (i == 0) enable = 1'b0;
      tick();
    end
    for (int k = 0; k < 20 && !(fft_we && fft_addr == 3'd7); k++) tick();
    chk("f2_last_write", fft_we, 1);
    tick();
    // fft_done while in KICK is ignored.
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("f2_sig", fft_sig, 1);
    chk("done_in_kick", frame_cnt, 1);
    tick(); tick();
    chk("f2_wait_busy", busy, 1);
    chk("f2_wait_frame_cnt", frame_cnt, 1);
    chk("f2_nwrites", wa.size(), N);
    for (int i = 0; i < wa.size() && i < N; i++) begin
      chk($sformatf("f2_addr%0d", i), wa[i], i);
      chk($sformatf("f2_din%0d", i), wd[i], {e2[i], 32'h0});
      if (i > 0) chk($sformatf("f2_gap%0d", i), wc[i] - wc[i-1], 2);
    end
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("f2_frame_cnt", frame_cnt, 2);
    chk("f2_idle_busy", busy, 0);
    chk("f2_idle_s_ready", s_ready, 0);

    // Frame 3: reset lands while the frame is draining.
    enable = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = v1[i];
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_fft_we", fft_we, 0);
    chk("mrst_fft_addr", fft_addr, 0);
    chk("mrst_fft_din", fft_din, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_frame_cnt", frame_cnt, 0);
    tick();
    rst = 1'b0;
    clear_logs();
    tick();
    s_valid = 1'b1;
    s_data  = 16'd5;
    tick();
    s_data  = 16'hFFF9;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("post_rst_nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("post_rst_addr0", wa[0], 0);
      chk("post_rst_din0", wd[0], {32'h40A0_0000, 32'h0});
      chk("post_rst_addr1", wa[1], 1);
      chk("post_rst_din1", wd[1], {32'hC0E0_0000, 32'h0});
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Upstream feeder for the FFT core. It accepts a stream of signed fixed-point samples and converts each one to an IEEE-754 single-precision real value with zero imaginary part. It writes each frame of N samples into the FFT data memory through the core's host port, with bit-reversal enabled, then pulses the FFT start signal. It waits for completion before loading the next frame.

## Interface
Parameters:
- LOGN, 12, log2 of frame length N (N = 2^LOGN)
- SW, 16, signed sample width; legal range 2..24, so conversion is always exact
- CW, 64, complex word width; real part in [CW-1:CW/2], imag part in [CW/2-1:0]; CW/2 = 32

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  level; permits starting a new frame
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid & s_ready
- s_data  in  SW  signed two's-complement sample
- fft_we  out  1  FFT memory write enable
- fft_rev  out  1  FFT bit-reverse address select
- fft_addr  out  LOGN  FFT memory address (natural order)
- fft_din  out  CW  FFT memory write data
- fft_sig  out  1  FFT start; one-cycle pulse
- fft_done  in  1  FFT finished; one-cycle pulse from top level
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  completed-frame counter; wraps modulo 2^16

## Operation
- States: IDLE, FILL, DRAIN, KICK, WAIT.
- IDLE:
  - if enable = 1, go to FILL; clear acc_cnt and wr_cnt.
- FILL:
  - s_ready = 1 while acc_cnt < N.
  - Each handshake increments acc_cnt and pushes the sample into the 2-stage converter.
  - When acc_cnt reaches N, s_ready drops in the same cycle; go to DRAIN.
- DRAIN:
  - Wait until wr_cnt = N, i.e. the last converter output has been written; then go to KICK.
- KICK:
  - fft_sig = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - s_ready = 0.
  - On fft_done, increment frame_cnt.
  - Then go to FILL if enable = 1, otherwise to IDLE.
- fft_done outside WAIT is ignored.
- enable deassertion mid-frame does not abort the frame. The current frame completes through WAIT, then the block goes to IDLE.
- Converter output:
  - Each output drives fft_we = 1, fft_addr = wr_cnt, fft_din = {float(sample), 32'h0}, fft_rev = 1.
  - wr_cnt then increments.
  - fft_rev = 1 whenever fft_we = 1; otherwise fft_rev = 0.
- Conversion rules:
  - sign = msb.
  - mag = |x|, computed SW+1 bits wide so that -2^(SW-1) is handled.
  - exponent = 127 + (position of leading one in mag).
  - mantissa = mag shifted left to drop the leading one, zero-padded to 23 bits.
  - x = 0 produces 32'h0000_0000.
  - No rounding is ever needed.
- Counters:
  - acc_cnt and wr_cnt are LOGN+1 bits wide, so they can hold the value N.
  - fft_addr = wr_cnt[LOGN-1:0].

## Timing
- Reset values: s_ready 0, fft_we 0, fft_rev 0, fft_addr 0, fft_din 0, fft_sig 0, busy 0, frame_cnt 0; state IDLE. Reset mid-frame discards all in-flight samples.
- Latency: a sample accepted at edge t appears on fft_we/fft_addr/fft_din after edge t+2. Converter stage 1 computes abs and leading-one position; stage 2 normalizes and packs. All outputs are registered.
- Back-to-back acceptance gives one write per cycle. Gaps in s_valid propagate as gaps in fft_we.
- The last write of a frame occurs 2 cycles after the Nth handshake.
- DRAIN → KICK transition happens on the edge after wr_cnt = N. fft_sig rises on the following edge, so at least one idle cycle separates the last fft_we from fft_sig.
- fft_done and the KICK→WAIT transition in the same cycle: fft_done is ignored; the block waits for the next pulse.
- Minimum turnaround: fft_done at cycle t gives s_ready = 1 at t+1.

## Structure
- Shared package:
  - FLT_BIAS = 127, FLT_MW = 23, FLT_EW = 8.
  - Real/imag field slice helpers for CW.
  - State enum encoding.
- One sub-module: int_to_float, a 2-stage pipeline with valid tag, parameterized on SW.
- Top of this block contains the FSM, the counters, and frame_cnt.

## Test plan
- LOGN=3, samples 0,1,-1,2,-32768,32767,100,-100 → writes at addr 0..7 with real parts 00000000, 3F800000, BF800000, 40000000, C7000000, 46FFFE00, 42C80000, C2C80000; imag 0; fft_rev=1 on every write.
- Continuous s_valid, LOGN=3 → 8 consecutive fft_we cycles; s_ready low after 8th handshake; single fft_sig pulse exactly 2 cycles after last write; no s_ready until fft_done.
- s_valid toggling every other cycle → addresses strictly sequential with gaps; frame completes with exactly N writes.
- fft_done pulse in FILL, then in WAIT → first ignored (frame_cnt unchanged); second increments frame_cnt 0→1 and returns to FILL.
- enable dropped during FILL → frame finishes, fft_sig fires, after fft_done state IDLE, busy=0, s_ready=0.
- rst asserted mid-DRAIN → all outputs 0 immediately; after release with enable=1, next frame writes start at addr 0.
